// File: rtl/ft_mcs_pkg.sv
// rtl/ft_mcs_pkg.sv - shared types and constants for the MCS/FT600 MMIO fabric
package ft_mcs_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OWN0,
      ARB_OWN1,
      ARB_TMO
   } arb_state_t;

   localparam logic [31:0] ARB_TMO_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - classic Wishbone bundle; DAT_I is write data, DAT_O is read data
interface wishbone_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  CYC;
   logic                  STB;
   logic                  WE;
   logic [ADDR_WIDTH-1:0] ADDR;
   logic [DATA_WIDTH-1:0] DAT_I;
   logic [DATA_WIDTH-1:0] DAT_O;
   logic                  ACK;

   modport master (output CYC, STB, WE, ADDR, DAT_I, input ACK, DAT_O);
   modport slave  (input CYC, STB, WE, ADDR, DAT_I, output ACK, DAT_O);
endinterface

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - per-transfer stall counter; expire fires on the last cycle without ACK
module wb_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic ack,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || ack || !en) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // An ACK landing on the final cycle beats the watchdog.
   assign expire = (TIMEOUT_CYCLES > 0) && en && !ack && (cnt_q == LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master round-robin Wishbone arbiter with stall watchdog
module wb_bus_arbiter
   import ft_mcs_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       CLK,
   input  logic       RST_N,
   wishbone_if.slave  m0,
   wishbone_if.slave  m1,
   wishbone_if.master s,
   output logic [1:0] grant,
   output logic       timeout_err,
   output logic [7:0] timeout_cnt
);

   localparam logic [DATA_WIDTH-1:0] TMO_DATA = DATA_WIDTH'(ARB_TMO_DATA);

   arb_state_t state_q, state_d;
   logic       last_owner_q, last_owner_d;
   logic       owner_q, owner_d;
   logic [7:0] tmo_cnt_q, tmo_cnt_d;

   logic                  own_cyc;
   logic                  own_stb;
   logic                  own_we;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0] own_wdat;
   logic                  is_own;
   logic                  wd_expire;

   assign is_own = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);

   always_comb begin
      if (owner_q) begin
         own_cyc  = m1.CYC;
         own_stb  = m1.STB;
         own_we   = m1.WE;
         own_addr = m1.ADDR;
         own_wdat = m1.DAT_I;
      end else begin
         own_cyc  = m0.CYC;
         own_stb  = m0.STB;
         own_we   = m0.WE;
         own_addr = m0.ADDR;
         own_wdat = m0.DAT_I;
      end
   end

   wb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (!is_own),
      .en    (is_own && own_stb),
      .ack   (is_own && s.ACK),
      .expire(wd_expire)
   );

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      tmo_cnt_d    = tmo_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (m0.CYC || m1.CYC) begin
               // On a tie the master that did not hold the bus last goes first.
               if (m0.CYC && m1.CYC) begin
                  owner_d = !last_owner_q;
               end else begin
                  owner_d = m1.CYC;
               end
               state_d = owner_d ? ARB_OWN1 : ARB_OWN0;
            end
         end
         ARB_OWN0, ARB_OWN1: begin
            if (!own_cyc) begin
               state_d      = ARB_IDLE;
               last_owner_d = owner_q;
            end else if (wd_expire) begin
               state_d = ARB_TMO;
               if (tmo_cnt_q != 8'hFF) begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
            end
         end
         ARB_TMO: begin
            state_d = owner_q ? ARB_OWN1 : ARB_OWN0;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ARB_IDLE;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         tmo_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   always_comb begin
      s.CYC    = 1'b0;
      s.STB    = 1'b0;
      s.WE     = 1'b0;
      s.ADDR   = '0;
      s.DAT_I  = '0;
      m0.ACK   = 1'b0;
      m0.DAT_O = '0;
      m1.ACK   = 1'b0;
      m1.DAT_O = '0;
      if (is_own) begin
         s.CYC   = own_cyc;
         s.STB   = own_stb;
         s.WE    = own_we;
         s.ADDR  = own_addr;
         s.DAT_I = own_wdat;
         if (owner_q) begin
            m1.ACK   = s.ACK;
            m1.DAT_O = s.DAT_O;
         end else begin
            m0.ACK   = s.ACK;
            m0.DAT_O = s.DAT_O;
         end
      end else if (state_q == ARB_TMO) begin
         // The slave is cut off; the owner gets a synthetic error-data ACK instead.
         if (owner_q) begin
            m1.ACK   = 1'b1;
            m1.DAT_O = TMO_DATA;
         end else begin
            m0.ACK   = 1'b1;
            m0.DAT_O = TMO_DATA;
         end
      end
   end

   assign grant       = (state_q == ARB_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
   assign timeout_err = (state_q == ARB_TMO);
   assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant;
   logic       timeout_err;
   logic [7:0] timeout_cnt;

   int checks = 0;
   int errors = 0;

   wishbone_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
   wishbone_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
   wishbone_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

   wb_bus_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .m0         (m0_if),
      .m1         (m1_if),
      .s          (s_if),
      .grant      (grant),
      .timeout_err(timeout_err),
      .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   // Slave stub: ACK after ack_delay wait cycles, read data {C0DE, addr[15:0]}, LED at 0x0.
   logic [7:0] sl_wait;
   logic [7:0] ack_delay = 8'd1;
   logic       ack_never = 1'b0;
   logic [7:0] led = 8'h00;
   int         err_pulses = 0;
   logic       other_ack;
   logic       burst_mon = 1'b0;
   int         burst_bad = 0;

   always_comb begin
      s_if.ACK   = s_if.CYC && s_if.STB && !ack_never && (sl_wait == ack_delay);
      s_if.DAT_O = '0;
      if (s_if.ACK && !s_if.WE) s_if.DAT_O = {16'hC0DE, s_if.ADDR[15:0]};
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_wait <= 8'd0;
      end else begin
         if (!(s_if.CYC && s_if.STB) || s_if.ACK) sl_wait <= 8'd0;
         else sl_wait <= sl_wait + 8'd1;
         if (s_if.ACK && s_if.WE && s_if.ADDR == 32'h0) led <= s_if.DAT_I[7:0];
      end
   end

   always @(posedge clk) if (timeout_err) err_pulses <= err_pulses + 1;
   always @(negedge clk) if (burst_mon && grant != 2'b10) burst_bad <= burst_bad + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int m, input logic cyc, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdat);
      if (m == 0) begin
         m0_if.CYC = cyc; m0_if.STB = cyc; m0_if.WE = we; m0_if.ADDR = addr; m0_if.DAT_I = wdat;
      end else begin
         m1_if.CYC = cyc; m1_if.STB = cyc; m1_if.WE = we; m1_if.ADDR = addr; m1_if.DAT_I = wdat;
      end
   endtask

   function automatic logic ack_of(input int m);
      return (m == 0) ? m0_if.ACK : m1_if.ACK;
   endfunction

   function automatic logic [31:0] dat_of(input int m);
      return (m == 0) ? m0_if.DAT_O : m1_if.DAT_O;
   endfunction

   // n = cycles from the first granted cycle to the ACK, or -1 if the budget ran out.
   task automatic wait_ack(input int m, input int budget, output logic [31:0] rdata, output int n);
      n = 0;
      while (!ack_of(m) && n < budget) begin
         if (ack_of(1 - m)) other_ack = 1'b1;
         tick();
         n++;
      end
      if (ack_of(1 - m)) other_ack = 1'b1;
      rdata = ack_of(m) ? dat_of(m) : 32'h0;
      if (!ack_of(m)) n = -1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   logic [31:0] rd;
   int          n;
   logic [1:0]  exp_grant [3];

   initial begin
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk_eq("rst_grant", 32'(grant), 32'h0);
      chk_eq("rst_scyc", 32'(s_if.CYC), 32'h0);
      chk_eq("rst_sstb", 32'(s_if.STB), 32'h0);
      chk_eq("rst_tmo_cnt", 32'(timeout_cnt), 32'h0);
      chk_eq("rst_tmo_err", 32'(timeout_err), 32'h0);
      do_reset();

      // m0 writes A5 to the LED slot.
      ack_delay = 8'd1;
      other_ack = 1'b0;
      drive(0, 1'b1, 1'b1, 32'h0, 32'h0000_00A5);
      #1;
      chk_eq("t1_bubble_grant", 32'(grant), 32'h0);
      tick();
      chk_eq("t1_grant", 32'(grant), 32'h1);
      chk_eq("t1_scyc", 32'(s_if.CYC), 32'h1);
      wait_ack(0, 20, rd, n);
      chk_eq("t1_ack_cycle", 32'(n), 32'd1);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk_eq("t1_led", 32'(led), 32'hA5);
      chk_eq("t1_m1_no_ack", 32'(other_ack), 32'h0);
      chk_eq("t1_idle_grant", 32'(grant), 32'h0);

      // Three simultaneous requests: round-robin starting from m0 after reset.
      do_reset();
      exp_grant[0] = 2'b01;
      exp_grant[1] = 2'b10;
      exp_grant[2] = 2'b01;
      for (int r = 0; r < 3; r++) begin
         int win;
         win = (exp_grant[r] == 2'b01) ? 0 : 1;
         other_ack = 1'b0;
         drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
         drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
         tick();
         chk_eq($sformatf("t2_grant_r%0d", r), 32'(grant), 32'(exp_grant[r]));
         wait_ack(win, 20, rd, n);
         chk_eq($sformatf("t2_rdata_r%0d", r), rd, (win == 0) ? 32'hC0DE_0010 : 32'hC0DE_0014);
         chk_eq($sformatf("t2_loser_ack_r%0d", r), 32'(other_ack), 32'h0);
         tick();
         drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
         drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end

      // m1 burst of four UART reads while m0 waits.
      other_ack = 1'b0;
      drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
      tick();
      chk_eq("t3_grant_m1", 32'(grant), 32'h2);
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      burst_mon = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_ack(1, 20, rd, n);
         chk_eq($sformatf("t3_rdata_b%0d", b), rd, 32'hC0DE_0020 + 32'(4 * b));
         tick();
         if (b < 3) drive(1, 1'b1, 1'b0, 32'h20 + 32'(4 * (b + 1)), 32'h0);
      end
      burst_mon = 1'b0;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_eq("t3_no_grant_change", 32'(burst_bad), 32'h0);
      chk_eq("t3_m0_no_ack", 32'(other_ack), 32'h0);
      tick();
      chk_eq("t3_handover_idle", 32'(grant), 32'h0);
      tick();
      chk_eq("t3_handover_m0", 32'(grant), 32'h1);
      wait_ack(0, 20, rd, n);
      chk_eq("t3_m0_rdata", rd, 32'hC0DE_0010);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Slave never answers: watchdog ACK at cycle 16.
      ack_never = 1'b1;
      drive(0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
      tick();
      chk_eq("t4_grant", 32'(grant), 32'h1);
      wait_ack(0, 40, rd, n);
      chk_eq("t4_ack_cycle", 32'(n), 32'd16);
      chk_eq("t4_tmo_data", rd, 32'hDEAD_BEEF);
      chk_eq("t4_tmo_err", 32'(timeout_err), 32'h1);
      chk_eq("t4_scyc_low", 32'(s_if.CYC), 32'h0);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      ack_never = 1'b0;
      tick();
      chk_eq("t4_tmo_cnt", 32'(timeout_cnt), 32'h1);
      chk_eq("t4_err_pulses", 32'(err_pulses), 32'h1);

      // ACK on cycle 15 beats the watchdog.
      ack_delay = 8'd15;
      drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      wait_ack(0, 40, rd, n);
      chk_eq("t5_ack_cycle", 32'(n), 32'd15);
      chk_eq("t5_rdata", rd, 32'hC0DE_0040);
      chk_eq("t5_tmo_err", 32'(timeout_err), 32'h0);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk_eq("t5_err_pulses", 32'(err_pulses), 32'h1);
      chk_eq("t5_tmo_cnt", 32'(timeout_cnt), 32'h1);

      // Async reset in the middle of an m1 transfer.
      ack_delay = 8'd8;
      drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
      tick();
      chk_eq("t6_grant_m1", 32'(grant), 32'h2);
      chk_eq("t6_scyc_before", 32'(s_if.CYC), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_eq("t6_scyc_async", 32'(s_if.CYC), 32'h0);
      chk_eq("t6_sstb_async", 32'(s_if.STB), 32'h0);
      chk_eq("t6_grant_async", 32'(grant), 32'h0);
      chk_eq("t6_tmo_cnt_rst", 32'(timeout_cnt), 32'h0);
      tick();
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
      tick();
      chk_eq("t6_post_rst_grant", 32'(grant), 32'h1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
